// File: rtl/serv_sleep_pkg.sv
// Shared definitions for the sleep/wakeup responder: state encoding,
// default settle delay and delay-counter sizing.
package serv_sleep_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_t;

  localparam int unsigned WAKE_DELAY_DEFAULT = 4;

  // Width of a down-counter that must hold d-1; never narrower than one bit.
  function automatic int unsigned dly_width(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/serv_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module serv_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serv_sleep_ctrl.sv
// Always-on sleep responder: drains the buses, gates the core clock while
// asleep and restarts the core after a settle delay with a wake_ack pulse.
module serv_sleep_ctrl
  import serv_sleep_pkg::*;
#(
  parameter int unsigned WAKE_DELAY = WAKE_DELAY_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_sleep_req,
  input  logic             i_wakeup_req,
  input  logic             i_ibus_busy,
  input  logic             i_dbus_busy,
  output logic             o_clk_en,
  output logic             o_sleeping,
  output logic             o_wake_ack,
  output logic [CNT_W-1:0] o_sleep_cycles
);

  localparam int unsigned DLY_W      = dly_width(WAKE_DELAY);
  localparam int unsigned DLY_LOAD_I = (WAKE_DELAY == 0) ? 0 : WAKE_DELAY - 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_LOAD_I[DLY_W-1:0];

  state_t           state;
  state_t           state_nxt;
  logic             ack;
  logic             ack_nxt;
  logic [DLY_W-1:0] dly;
  logic             cnt_clr;
  logic             cnt_en;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RUN;
      ack   <= 1'b0;
      dly   <= '0;
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
      if ((state == SLEEP) && (state_nxt == WAKE)) begin
        dly <= DLY_LOAD;
      end else if ((state == WAKE) && (dly != '0)) begin
        dly <= dly - 1'b1;
      end
    end
  end

  // ack_nxt marks every entry into RUN, plus the WFI-as-NOP case in RUN.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (i_sleep_req) begin
          if (i_wakeup_req) begin
            ack_nxt = 1'b1;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (i_wakeup_req) begin
          state_nxt = RUN;
          ack_nxt   = 1'b1;
        end else if (!i_ibus_busy && !i_dbus_busy) begin
          state_nxt = SLEEP;
        end
      end
      SLEEP: begin
        if (i_wakeup_req) begin
          if (WAKE_DELAY == 0) begin
            state_nxt = RUN;
            ack_nxt   = 1'b1;
          end else begin
            state_nxt = WAKE;
          end
        end
      end
      WAKE: begin
        if (dly == '0) begin
          state_nxt = RUN;
          ack_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_comb begin
    o_clk_en   = (state == RUN) || (state == DRAIN);
    o_sleeping = (state == SLEEP) || (state == WAKE);
    o_wake_ack = ack;
  end

  assign cnt_clr = (state == DRAIN) && (state_nxt == SLEEP);
  assign cnt_en  = (state == SLEEP);

  serv_sat_cnt #(
    .W (CNT_W)
  ) u_sleep_cnt (
    .clk (clk),
    .rst (i_rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (o_sleep_cycles)
  );

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Directed scoreboard bench: dut_a uses WAKE_DELAY=4/CNT_W=32,
// dut_b uses WAKE_DELAY=0/CNT_W=4 for the boundary cases.
module tb_serv_sleep_ctrl;

  localparam int unsigned A = 0;
  localparam int unsigned B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_slp, a_wk, a_ib, a_db;
  logic        a_en, a_sl, a_ack;
  logic [31:0] a_cnt;
  logic        b_slp, b_wk, b_ib, b_db;
  logic        b_en, b_sl, b_ack;
  logic [3:0]  b_cnt;

  typedef struct {
    string       tag;
    logic [2:0]  flags;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  serv_sleep_ctrl #(.WAKE_DELAY(4), .CNT_W(32)) dut_a (
    .clk(clk), .i_rst(rst), .i_sleep_req(a_slp), .i_wakeup_req(a_wk),
    .i_ibus_busy(a_ib), .i_dbus_busy(a_db), .o_clk_en(a_en),
    .o_sleeping(a_sl), .o_wake_ack(a_ack), .o_sleep_cycles(a_cnt)
  );

  serv_sleep_ctrl #(.WAKE_DELAY(0), .CNT_W(4)) dut_b (
    .clk(clk), .i_rst(rst), .i_sleep_req(b_slp), .i_wakeup_req(b_wk),
    .i_ibus_busy(b_ib), .i_dbus_busy(b_db), .o_clk_en(b_en),
    .o_sleeping(b_sl), .o_wake_ack(b_ack), .o_sleep_cycles(b_cnt)
  );

  task automatic drive(input int unsigned which, input logic slp, input logic wk,
                       input logic ib, input logic db);
    if (which == A) begin
      a_slp = slp; a_wk = wk; a_ib = ib; a_db = db;
      b_slp = 1'b0; b_wk = 1'b0; b_ib = 1'b0; b_db = 1'b0;
    end else begin
      b_slp = slp; b_wk = wk; b_ib = ib; b_db = db;
      a_slp = 1'b0; a_wk = 1'b0; a_ib = 1'b0; a_db = 1'b0;
    end
  endtask

  task automatic push_exp(input string tag, input logic en, input logic sl,
                          input logic ack, input bit chk_cnt, input logic [31:0] cnt);
    exp_t e;
    e.tag     = tag;
    e.flags   = {en, sl, ack};
    e.chk_cnt = chk_cnt;
    e.cnt     = cnt;
    sb.push_back(e);
  endtask

  task automatic check_out(input int unsigned which);
    exp_t        e;
    logic [2:0]  obs_flags;
    logic [31:0] obs_cnt;
    e         = sb.pop_front();
    obs_flags = (which == A) ? {a_en, a_sl, a_ack} : {b_en, b_sl, b_ack};
    obs_cnt   = (which == A) ? a_cnt : {28'd0, b_cnt};
    n_total++;
    assert (obs_flags === e.flags) n_pass++;
    else $error("FAIL %s {clk_en,sleeping,wake_ack} got %b expected %b",
                e.tag, obs_flags, e.flags);
    if (e.chk_cnt) begin
      n_total++;
      assert (obs_cnt === e.cnt) n_pass++;
      else $error("FAIL %s sleep_cycles got %0d expected %0d", e.tag, obs_cnt, e.cnt);
    end
  endtask

  // One clock: apply inputs, record what must appear after the edge, compare.
  task automatic cyc(input string tag, input int unsigned which,
                     input logic slp, input logic wk, input logic ib, input logic db,
                     input logic en, input logic sl, input logic ack,
                     input bit chk_cnt, input logic [31:0] cnt);
    drive(which, slp, wk, ib, db);
    push_exp(tag, en, sl, ack, chk_cnt, cnt);
    @(posedge clk);
    #1;
    check_out(which);
  endtask

  initial begin
    rst = 1'b1;
    drive(A, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    push_exp("reset_a", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    check_out(A);
    push_exp("reset_b", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    check_out(B);
    #5 rst = 1'b0;

    // Basic sleep, 10 cycles asleep, WAKE_DELAY=4; sleep_req toggled while asleep.
    cyc("t2_req",  A, 1, 0, 0, 0, 1, 0, 0, 1'b0, 32'd0);
    cyc("t2_gate", A, 0, 0, 0, 0, 0, 1, 0, 1'b1, 32'd0);
    for (int k = 1; k <= 9; k++)
      cyc("t2_hold", A, 1'(k % 2), 0, 0, 0, 0, 1, 0, 1'b1, 32'(k));
    cyc("t2_wake_in", A, 0, 1, 0, 0, 0, 1, 0, 1'b1, 32'd10);
    for (int k = 0; k < 3; k++)
      cyc("t2_wake", A, 0, 1, 0, 0, 0, 1, 0, 1'b1, 32'd10);
    cyc("t2_resume",  A, 0, 1, 0, 0, 1, 0, 1, 1'b1, 32'd10);
    cyc("t2_ack_end", A, 0, 0, 0, 0, 1, 0, 0, 1'b1, 32'd10);

    // Drain with dbus busy for three cycles.
    cyc("t3_req",  A, 1, 0, 0, 1, 1, 0, 0, 1'b1, 32'd10);
    cyc("t3_busy", A, 0, 0, 0, 1, 1, 0, 0, 1'b1, 32'd10);
    cyc("t3_busy", A, 0, 0, 0, 1, 1, 0, 0, 1'b1, 32'd10);
    cyc("t3_gate", A, 0, 0, 0, 0, 0, 1, 0, 1'b1, 32'd0);

    // Wakeup dropped during WAKE still completes.
    cyc("t6c_wake_in", A, 0, 1, 0, 0, 0, 1, 0, 1'b1, 32'd1);
    for (int k = 0; k < 3; k++)
      cyc("t6c_wake_drop", A, 0, 0, 0, 0, 0, 1, 0, 1'b1, 32'd1);
    cyc("t6c_resume", A, 0, 0, 0, 0, 1, 0, 1, 1'b1, 32'd1);

    // Sleep request in the ack cycle re-enters DRAIN; wakeup in DRAIN while busy.
    cyc("t_ack_resleep", A, 1, 0, 1, 0, 1, 0, 0, 1'b1, 32'd1);
    cyc("t5_drain_hold", A, 0, 0, 1, 0, 1, 0, 0, 1'b1, 32'd1);
    cyc("t5_wake_busy",  A, 0, 1, 1, 0, 1, 0, 1, 1'b1, 32'd1);
    cyc("t5_ack_end",    A, 0, 0, 0, 0, 1, 0, 0, 1'b1, 32'd1);
    // Wakeup beats bus idle in DRAIN.
    cyc("t5_req2",      A, 1, 0, 0, 0, 1, 0, 0, 1'b1, 32'd1);
    cyc("t5_wake_idle", A, 0, 1, 0, 0, 1, 0, 1, 1'b1, 32'd1);
    cyc("t5_ack_end2",  A, 0, 0, 0, 0, 1, 0, 0, 1'b1, 32'd1);

    // Simultaneous sleep and wakeup in RUN: WFI as NOP.
    cyc("t4_both",    A, 1, 1, 0, 0, 1, 0, 1, 1'b1, 32'd1);
    cyc("t4_ack_end", A, 0, 0, 0, 0, 1, 0, 0, 1'b1, 32'd1);

    // Asynchronous reset in the middle of SLEEP.
    cyc("t1_req",   A, 1, 0, 0, 0, 1, 0, 0, 1'b1, 32'd1);
    cyc("t1_gate",  A, 0, 0, 0, 0, 0, 1, 0, 1'b1, 32'd0);
    cyc("t1_sleep", A, 0, 0, 0, 0, 0, 1, 0, 1'b1, 32'd1);
    #2 rst = 1'b1;
    #1;
    push_exp("t1_async_rst", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    check_out(A);
    #2 rst = 1'b0;
    cyc("t1_after", A, 0, 0, 0, 0, 1, 0, 0, 1'b1, 32'd0);

    // WAKE_DELAY=0 and 4-bit counter saturation.
    cyc("t6_req",  B, 1, 0, 0, 0, 1, 0, 0, 1'b1, 32'd0);
    cyc("t6_gate", B, 0, 0, 0, 0, 0, 1, 0, 1'b1, 32'd0);
    for (int k = 1; k <= 20; k++)
      cyc("t6_sat", B, 0, 0, 0, 0, 0, 1, 0, 1'b1, (k > 15) ? 32'd15 : 32'(k));
    cyc("t6_wd0",     B, 0, 1, 0, 0, 1, 0, 1, 1'b1, 32'd15);
    cyc("t6_ack_end", B, 0, 0, 0, 0, 1, 0, 0, 1'b1, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serv_sleep_ctrl.md
Name: serv_sleep_ctrl

Overview:
- Responder side of the core's sleep/wakeup request pair.
- Consumes the core's sleep request and its wakeup (enabled pending interrupt) request.
- Drains outstanding bus activity, gates the core clock, and restarts the core after a programmable settle delay.
- Sits in the always-on domain: runs on the free-running clock, never on the gated clock it produces.

Parameters:
- WAKE_DELAY, 4: cycles the clock stays gated in WAKE before the core resumes. 0 means WAKE is skipped.
- CNT_W, 32: width of the sleep-cycle counter.

Ports:
- clk  in  1  free-running clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_sleep_req  in  1  core requests sleep (WFI at end of instruction).
- i_wakeup_req  in  1  enabled interrupt pending (level).
- i_ibus_busy  in  1  instruction bus transaction outstanding.
- i_dbus_busy  in  1  data bus transaction outstanding.
- o_clk_en  out  1  core clock-gate enable (registered).
- o_sleeping  out  1  high while state is SLEEP or WAKE.
- o_wake_ack  out  1  one-cycle pulse telling the core to retire the WFI.
- o_sleep_cycles  out  CNT_W  length of the last or current SLEEP episode.

Behaviour:
- Reset (async, i_rst=1):
  - state=RUN, o_clk_en=1, o_sleeping=0, o_wake_ack=0, o_sleep_cycles=0, delay counter=0.
  - Reset asserted in any state forces RUN with the clock enabled immediately.
- All outputs are registered. o_sleeping, o_clk_en and o_wake_ack are decoded from the registered state and flags.
- RUN: o_clk_en=1.
  - i_sleep_req & !i_wakeup_req -> DRAIN.
  - i_sleep_req & i_wakeup_req -> stay in RUN; o_wake_ack=1 next cycle (WFI acts as a NOP).
- DRAIN: o_clk_en=1.
  - i_wakeup_req -> RUN with an o_wake_ack pulse. Wakeup has priority over bus idle.
  - Else, when !i_ibus_busy & !i_dbus_busy -> SLEEP; o_sleep_cycles cleared to 0 on this transition.
- SLEEP: o_clk_en=0, o_sleeping=1.
  - o_sleep_cycles increments each cycle in SLEEP and saturates at 2^CNT_W-1; it does not wrap.
  - i_wakeup_req -> WAKE with delay counter loaded to WAKE_DELAY-1. If WAKE_DELAY=0, go directly to RUN.
- WAKE: o_clk_en=0, o_sleeping=1.
  - Delay counter decrements each cycle; at 0 -> RUN.
  - Deassertion of i_wakeup_req during WAKE is ignored; the wake is committed.
- Entry to RUN from DRAIN, WAKE or SLEEP: o_clk_en=1 and o_wake_ack=1 in that same first RUN cycle, exactly one cycle wide.
- o_sleep_cycles holds its value after wake until the next DRAIN->SLEEP transition.
- i_sleep_req is ignored outside RUN.
- A new i_sleep_req in the cycle o_wake_ack is high is accepted normally (re-enters DRAIN).
- Latency:
  - Sleep request to clock gated: 1 + drain cycles.
  - Wakeup in SLEEP to clock enabled: WAKE_DELAY + 1 cycles.

Decomposition:
- Package serv_sleep_pkg holds:
  - state encoding constants: RUN=2'd0, DRAIN=2'd1, SLEEP=2'd2, WAKE=2'd3;
  - the default WAKE_DELAY value.
- One sub-module is natural: serv_sat_cnt, a parameterised-width saturating up-counter with synchronous clear, used for o_sleep_cycles.
- The delay down-counter stays inline.

Test Plan:
1. Reset mid-SLEEP (o_clk_en=0) -> o_clk_en=1 and o_sleeping=0 asynchronously, before the next clk edge; o_sleep_cycles=0.
2. Basic sleep:
   - stimulus: pulse i_sleep_req, buses idle, hold 10 cycles, then raise i_wakeup_req, WAKE_DELAY=4;
   - response: o_clk_en=0 from cycle 2; o_sleep_cycles=10 when WAKE is entered; o_clk_en=1 and o_wake_ack=1 for one cycle, 5 cycles after the wakeup rise.
3. Drain:
   - stimulus: i_sleep_req with i_dbus_busy high for 3 cycles;
   - response: o_clk_en stays 1 for those 3 cycles and drops the cycle after i_dbus_busy falls.
4. Simultaneous i_sleep_req & i_wakeup_req in RUN -> o_clk_en never drops; single o_wake_ack pulse next cycle.
5. i_wakeup_req during DRAIN (bus busy) -> return to RUN with o_wake_ack; o_sleeping never asserted.
6. Boundaries:
   - WAKE_DELAY=0 -> clock re-enabled 1 cycle after the wakeup rise.
   - CNT_W=4 with sleep held 20 cycles -> o_sleep_cycles saturates at 15.
   - Wakeup dropped during WAKE -> wake still completes.
